// File: rtl/branch_resolve_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// branch_resolve_ctrl_pkg : shared branch-table entry, counter and FSM types
// Rev 1.0
// ------------------------------------------------------------------
package branch_resolve_ctrl_pkg;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  // Tag is stored right-justified; bits above the configured tag width stay zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  cnt;
  } branch_entry_t;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    case (cnt)
      STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
      default:   nxt = taken ? STRONG_T : WEAK_T;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_ctrl_table.sv
`default_nettype none
// ------------------------------------------------------------------
// branch_table : direct-mapped branch table, combinational lookup, registered update
// Rev 1.0
// ------------------------------------------------------------------
module branch_table
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:2] lookup_addr,
  output logic        lookup_taken,
  output logic [31:0] lookup_target,
  input  logic        upd_valid,
  input  logic [31:2] upd_addr,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);

  branch_entry_t table_q [ENTRIES];
  branch_entry_t table_d [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [29:0]      lk_tag, upd_tag;
  branch_entry_t    lk_e, upd_e;

  assign lk_idx  = lookup_addr[IDX_W+1:2];
  assign lk_tag  = 30'(lookup_addr[31:IDX_W+2]);
  assign upd_idx = upd_addr[IDX_W+1:2];
  assign upd_tag = 30'(upd_addr[31:IDX_W+2]);

  // Reads the current array only: a write on this edge is not forwarded.
  assign lk_e          = table_q[lk_idx];
  assign lookup_taken  = lk_e.valid && (lk_e.tag == lk_tag) && lk_e.cnt[1];
  assign lookup_target = lk_e.target;

  always_comb begin
    table_d = table_q;
    upd_e   = table_q[upd_idx];
    if (upd_valid) begin
      if (upd_e.valid && (upd_e.tag == upd_tag)) begin
        upd_e.cnt = cnt_next(upd_e.cnt, upd_taken);
        if (upd_taken) begin
          upd_e.target = upd_target;
        end
      end else if (upd_taken) begin
        upd_e = '{valid: 1'b1, tag: upd_tag, target: upd_target, cnt: WEAK_T};
      end
      table_d[upd_idx] = upd_e;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      table_q <= table_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// branch_resolve_ctrl : branch table owner, mispredict redirect FSM, statistics
// Rev 1.0
// ------------------------------------------------------------------
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int CNT_SAT = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        fetch_pc,
  output logic               pred_taken,
  output logic [31:0]        pred_target,
  input  logic               resolve_valid,
  input  logic [31:0]        resolve_pc,
  input  logic               resolve_taken,
  input  logic [31:0]        resolve_target,
  input  logic               resolve_pred_taken,
  input  logic [31:0]        resolve_pred_target,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  input  logic               redirect_ack,
  output logic [CNT_SAT-1:0] mispredict_count
);

  state_e             state_q, state_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [CNT_SAT-1:0] count_q, count_d;
  logic               upd_valid_q, upd_valid_d;
  logic [31:2]        upd_addr_q, upd_addr_d;
  logic               upd_taken_q, upd_taken_d;
  logic [31:0]        upd_target_q, upd_target_d;

  logic               tbl_taken;
  logic [31:0]        tbl_target;
  logic               mispredict;

  branch_table #(.ENTRIES(ENTRIES)) u_table (
    .CLK           (CLK),
    .RST           (RST),
    .lookup_addr   (fetch_pc[31:2]),
    .lookup_taken  (tbl_taken),
    .lookup_target (tbl_target),
    .upd_valid     (upd_valid_q),
    .upd_addr      (upd_addr_q),
    .upd_taken     (upd_taken_q),
    .upd_target    (upd_target_q)
  );

  assign pred_taken  = tbl_taken;
  assign pred_target = tbl_taken ? tbl_target : fetch_pc + 32'd4;

  assign mispredict = (resolve_taken != resolve_pred_taken) ||
                      (resolve_taken && (resolve_target != resolve_pred_target));

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    count_d       = count_q;
    upd_valid_d   = 1'b0;
    upd_addr_d    = resolve_pc[31:2];
    upd_taken_d   = resolve_taken;
    upd_target_d  = resolve_target;
    case (state_q)
      ST_IDLE: begin
        if (resolve_valid) begin
          upd_valid_d = 1'b1;
          if (mispredict) begin
            state_d       = ST_REDIRECT;
            redirect_pc_d = resolve_taken ? resolve_target : resolve_pc + 32'd4;
            if (count_q != {CNT_SAT{1'b1}}) begin
              count_d = count_q + {{(CNT_SAT-1){1'b0}}, 1'b1};
            end
          end
        end
      end
      // Resolves seen here are wrong-path and must not train the table.
      ST_REDIRECT: begin
        if (redirect_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      redirect_pc_q <= '0;
      count_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_addr_q    <= '0;
      upd_taken_q   <= 1'b0;
      upd_target_q  <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      count_q       <= count_d;
      upd_valid_q   <= upd_valid_d;
      upd_addr_q    <= upd_addr_d;
      upd_taken_q   <= upd_taken_d;
      upd_target_q  <= upd_target_d;
    end
  end

  assign redirect_valid   = (state_q == ST_REDIRECT);
  assign redirect_pc      = redirect_pc_q;
  assign mispredict_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_branch_resolve_ctrl : directed vector table, corner sequences, random vs reference model
// Rev 1.0
// ------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] fetch_pc = '0;
  logic        resolve_valid = 1'b0;
  logic [31:0] resolve_pc = '0;
  logic        resolve_taken = 1'b0;
  logic [31:0] resolve_target = '0;
  logic        resolve_pred_taken = 1'b0;
  logic [31:0] resolve_pred_target = '0;
  logic        redirect_ack = 1'b0;

  logic        pred_taken, s_pred_taken;
  logic [31:0] pred_target, s_pred_target;
  logic        redirect_valid, s_redirect_valid;
  logic [31:0] redirect_pc, s_redirect_pc;
  logic [15:0] mispredict_count;
  logic [3:0]  s_mispredict_count;

  int tests = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  branch_resolve_ctrl dut (
    .CLK(CLK), .RST(RST), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .resolve_pred_taken(resolve_pred_taken), .resolve_pred_target(resolve_pred_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack), .mispredict_count(mispredict_count)
  );

  // Narrow statistics counter so saturation is reachable in a short run.
  branch_resolve_ctrl #(.ENTRIES(4), .CNT_SAT(4)) dut_sat (
    .CLK(CLK), .RST(RST), .fetch_pc(fetch_pc),
    .pred_taken(s_pred_taken), .pred_target(s_pred_target),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .resolve_pred_taken(resolve_pred_taken), .resolve_pred_target(resolve_pred_target),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .redirect_ack(redirect_ack), .mispredict_count(s_mispredict_count)
  );

  // ---------------- reference model ----------------
  bit          m_valid [4];
  logic [27:0] m_tag   [4];
  logic [31:0] m_tgt   [4];
  int          m_cnt   [4];
  bit          p_valid;
  logic [31:0] p_pc, p_tgt;
  bit          p_taken;
  bit          m_redir;
  logic [31:0] m_rpc;
  longint      m_nmp;

  function automatic void m_lookup(input logic [31:0] pc, output bit pt, output logic [31:0] tg);
    int i;
    i  = int'(pc[3:2]);
    pt = m_valid[i] && (m_tag[i] == pc[31:4]) && (m_cnt[i] >= 2);
    tg = pt ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 0;
    end
    p_valid = 0; m_redir = 0; m_rpc = '0; m_nmp = 0;
  endfunction

  function automatic void m_edge();
    int i;
    bit mp;
    if (RST) begin
      m_reset();
      return;
    end
    if (p_valid) begin
      i = int'(p_pc[3:2]);
      if (m_valid[i] && m_tag[i] == p_pc[31:4]) begin
        m_cnt[i] = p_taken ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
        if (p_taken) m_tgt[i] = p_tgt;
      end else if (p_taken) begin
        m_valid[i] = 1; m_tag[i] = p_pc[31:4]; m_tgt[i] = p_tgt; m_cnt[i] = 2;
      end
    end
    p_valid = 0;
    if (!m_redir) begin
      if (resolve_valid) begin
        p_valid = 1; p_pc = resolve_pc; p_taken = resolve_taken; p_tgt = resolve_target;
        mp = (resolve_taken != resolve_pred_taken) ||
             (resolve_taken && resolve_target != resolve_pred_target);
        if (mp) begin
          m_redir = 1;
          m_rpc   = resolve_taken ? resolve_target : resolve_pc + 32'd4;
          m_nmp++;
        end
      end
    end else if (redirect_ack) begin
      m_redir = 0;
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    m_edge();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] fpc, input bit rv, input logic [31:0] rpc, input bit rt,
                       input logic [31:0] rtg, input bit rpt, input logic [31:0] rptg, input bit ack);
    fetch_pc = fpc; resolve_valid = rv; resolve_pc = rpc; resolve_taken = rt;
    resolve_target = rtg; resolve_pred_taken = rpt; resolve_pred_target = rptg; redirect_ack = ack;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst; logic [31:0] fpc; bit rv; logic [31:0] rpc; bit rt; logic [31:0] rtg;
    bit rpt; logic [31:0] rptg; bit ack;
    bit e_pt; logic [31:0] e_ptg; bit e_rv; logic [31:0] e_rpc; logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input bit rst, input logic [31:0] fpc, input bit rv, input logic [31:0] rpc,
                     input bit rt, input logic [31:0] rtg, input bit rpt, input logic [31:0] rptg,
                     input bit ack, input bit e_pt, input logic [31:0] e_ptg, input bit e_rv,
                     input logic [31:0] e_rpc, input logic [15:0] e_cnt);
    vec_t v;
    v = '{rst, fpc, rv, rpc, rt, rtg, rpt, rptg, ack, e_pt, e_ptg, e_rv, e_rpc, e_cnt};
    vecs.push_back(v);
  endtask

  initial begin
    bit          pt;
    logic [31:0] tg;

    m_reset();
    // rst fpc rv rpc rt rtg rpt rptg ack | pt ptg rv rpc cnt
    row(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,          0, 32'h44, 0, 32'h0, 0);
    row(0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0,      0, 32'h44, 1, 32'h100, 1);
    row(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,          1, 32'h100, 1, 32'h100, 1);
    row(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,          1, 32'h100, 1, 32'h100, 1);
    row(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,          1, 32'h100, 1, 32'h100, 1);
    row(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1,          1, 32'h100, 0, 32'h0, 1);
    row(0, 32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 0,     1, 32'h100, 0, 32'h0, 1);
    row(0, 32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 0,     1, 32'h100, 0, 32'h0, 1);
    row(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,          1, 32'h100, 0, 32'h0, 1);
    row(0, 32'h40, 1, 32'h40, 0, 32'h0, 1, 32'h100, 0,       1, 32'h100, 1, 32'h44, 2);
    row(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1,          1, 32'h100, 0, 32'h0, 2);
    row(0, 32'h40, 1, 32'h1040, 1, 32'h200, 0, 32'h1044, 0,  1, 32'h100, 1, 32'h200, 3);
    row(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1,          0, 32'h44, 0, 32'h0, 3);
    row(0, 32'h1040, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,        1, 32'h200, 0, 32'h0, 3);
    row(0, 32'h80, 1, 32'h44, 1, 32'h500, 0, 32'h48, 0,      0, 32'h84, 1, 32'h500, 4);
    row(0, 32'h80, 1, 32'h80, 1, 32'h900, 0, 32'h84, 0,      0, 32'h84, 1, 32'h500, 4);
    row(0, 32'h80, 1, 32'h80, 1, 32'h900, 0, 32'h84, 1,      0, 32'h84, 0, 32'h0, 4);
    row(0, 32'h80, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,          0, 32'h84, 0, 32'h0, 4);
    row(0, 32'h1040, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,        1, 32'h200, 0, 32'h0, 4);
    row(0, 32'h44, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,          1, 32'h500, 0, 32'h0, 4);
    row(0, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,    0, 32'h0, 0, 32'h0, 4);
    row(0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0, 1, 32'h1234, 0, 0, 32'h0, 1, 32'h0, 5);
    row(0, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1,    0, 32'h0, 0, 32'h0, 5);
    row(0, 32'h1040, 1, 32'h1040, 1, 32'h240, 1, 32'h200, 0, 1, 32'h200, 1, 32'h240, 6);
    row(0, 32'h1040, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1,        1, 32'h240, 0, 32'h0, 6);
    row(0, 32'h48, 1, 32'h48, 1, 32'h600, 0, 32'h4C, 0,      0, 32'h4C, 1, 32'h600, 7);
    row(1, 32'h1040, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,        0, 32'h1044, 0, 32'h0, 0);
    row(0, 32'h48, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,          0, 32'h4C, 0, 32'h0, 0);
    row(0, 32'h44, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,          0, 32'h48, 0, 32'h0, 0);
    row(0, 32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0,          0, 32'h44, 0, 32'h0, 0);

    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;

    foreach (vecs[k]) begin
      RST = vecs[k].rst;
      drive(vecs[k].fpc, vecs[k].rv, vecs[k].rpc, vecs[k].rt, vecs[k].rtg,
            vecs[k].rpt, vecs[k].rptg, vecs[k].ack);
      tick();
      chk($sformatf("vec%0d pred_taken", k), {31'b0, pred_taken}, {31'b0, vecs[k].e_pt});
      chk($sformatf("vec%0d pred_target", k), pred_target, vecs[k].e_ptg);
      chk($sformatf("vec%0d redirect_valid", k), {31'b0, redirect_valid}, {31'b0, vecs[k].e_rv});
      if (vecs[k].e_rv || vecs[k].rst)
        chk($sformatf("vec%0d redirect_pc", k), redirect_pc, vecs[k].e_rpc);
      chk($sformatf("vec%0d count", k), {16'b0, mispredict_count}, {16'b0, vecs[k].e_cnt});
      chk($sformatf("vec%0d sat_count", k), {28'b0, s_mispredict_count}, {28'b0, vecs[k].e_cnt[3:0]});
    end
    RST = 1'b0;

    // ---------------- counter saturation sequence ----------------
    RST = 1'b1; drive(32'h40, 0, 0, 0, 0, 0, 0, 0); tick(); RST = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      drive(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0); tick();
      drive(32'h40, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1); tick();
      if (n == 15 || n == 16 || n == 20) begin
        chk($sformatf("sat n=%0d narrow", n), {28'b0, s_mispredict_count}, 32'd15 < n ? 32'd15 : n);
        chk($sformatf("sat n=%0d wide", n), {16'b0, mispredict_count}, n);
      end
    end

    // ---------------- randomized run vs reference model ----------------
    RST = 1'b1; drive(32'h0, 0, 0, 0, 0, 0, 0, 0); tick(); RST = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] rpc_r, tgt_r;
      bit          rt_r;
      rpc_r = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC
              : (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 2) | 32'h40;
      tgt_r = 32'($urandom_range(1, 8)) << 8;
      rt_r  = $urandom_range(0, 1) == 1;
      m_lookup(rpc_r, pt, tg);
      if ($urandom_range(0, 9) < 3) begin
        pt = $urandom_range(0, 1) == 1;
        tg = 32'($urandom_range(1, 8)) << 8;
      end
      RST = ($urandom_range(0, 199) == 0);
      drive((32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 2) | 32'h40,
            $urandom_range(0, 1) == 1, rpc_r, rt_r, tgt_r, pt, tg, $urandom_range(0, 9) < 4);
      tick();
      m_lookup(fetch_pc, pt, tg);
      chk("rnd pred_taken", {31'b0, pred_taken}, {31'b0, pt});
      chk("rnd pred_target", pred_target, tg);
      chk("rnd redirect_valid", {31'b0, redirect_valid}, {31'b0, m_redir});
      if (m_redir) chk("rnd redirect_pc", redirect_pc, m_rpc);
      chk("rnd count", {16'b0, mispredict_count}, (m_nmp > 65535) ? 32'd65535 : 32'(m_nmp));
      chk("rnd sat_count", {28'b0, s_mispredict_count}, (m_nmp > 15) ? 32'd15 : 32'(m_nmp));
    end
    RST = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Controls the direct-mapped branch table used by fetch. It owns the table storage and answers fetch-stage lookups. It sequences table updates from branches resolved in EX.
- It detects mispredictions and drives a held redirect/flush request to fetch until fetch acknowledges it.
- It sits between the fetch PC mux and the EX-stage branch-resolution logic.

Parameters:
- ENTRIES, 4, number of table entries; must be a power of two. IDX_W = log2(ENTRIES), TAG_W = 30 - IDX_W.
- CNT_SAT, 16, width of the saturating mispredict statistics counter.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- fetch_pc  in  32  PC being fetched; lookup index is fetch_pc[IDX_W+1:2], tag is fetch_pc[31:IDX_W+2]
- pred_taken  out  1  combinational: entry valid, tag hit and counter[1]==1
- pred_target  out  32  combinational: entry target when pred_taken, else fetch_pc+4
- resolve_valid  in  1  EX has a resolved branch this cycle
- resolve_pc  in  32  PC of the resolved branch
- resolve_taken  in  1  actual outcome
- resolve_target  in  32  actual taken target
- resolve_pred_taken  in  1  prediction carried down the pipe
- resolve_pred_target  in  32  predicted next PC carried down the pipe
- redirect_valid  out  1  flush and redirect request to fetch
- redirect_pc  out  32  correct next PC
- redirect_ack  in  1  fetch accepted the redirect
- mispredict_count  out  CNT_SAT  saturating count of mispredictions

Behaviour:
- Reset (RST high at a posedge):
  - All entries get valid=0, tag=0, target=0, counter=2'b00.
  - FSM goes to IDLE.
  - redirect_valid=0, redirect_pc=0, mispredict_count=0.
  - Reset asserted while in REDIRECT drops the request on the next edge.
- Lookup is purely combinational from current table contents. There is no write-to-read bypass: a lookup in the cycle of a write sees the old entry.
- FSM states: IDLE, REDIRECT.
- IDLE, resolve_valid=1 at edge T:
  - The update is registered and written into the table at edge T+1; it is visible to lookup from T+1 onward.
  - mispredict = (resolve_taken != resolve_pred_taken) OR (resolve_taken AND resolve_target != resolve_pred_target).
  - If mispredict: go to REDIRECT at T. redirect_valid=1 from T. redirect_pc = resolve_taken ? resolve_target : resolve_pc+4. mispredict_count increments, saturating at all-ones.
  - If no mispredict: stay in IDLE.
- REDIRECT:
  - redirect_valid and redirect_pc are held stable until an edge with redirect_ack=1, then the FSM returns to IDLE with redirect_valid=0.
  - resolve_valid is ignored entirely while in REDIRECT, including a resolve coincident with redirect_ack (these are wrong-path branches). No table update and no count.
  - redirect_ack in IDLE is ignored.
- Table update rules (index and tag taken from resolve_pc):
  - Hit (valid and tag match): counter saturating-increments if taken, decrements if not taken. Target is overwritten with resolve_target if taken.
  - Miss and taken: allocate, replacing any occupant. Set valid=1, tag, target, counter=2'b10.
  - Miss and not taken: no change.
- Counter arithmetic is 2-bit saturating: 2'b11 stays 2'b11 on taken, and 2'b00 stays 2'b00 on not taken.
- pc+4 arithmetic wraps modulo 2^32. 0xFFFFFFFC+4 = 0x00000000.

Decomposition:
- The per-entry record (valid, tag, target, 2-bit counter) belongs in the shared cpu types package as the existing branch entry typedef.
- Also in the shared package:
  - counter encoding constants STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11;
  - FSM state enum for IDLE and REDIRECT.
- One sub-module: branch_table. It holds the storage, provides the combinational lookup port, and applies the registered update port and saturating-counter rules. The FSM and statistics counter stay in the top level.

Test Plan:
- Reset, then lookup fetch_pc=0x00000040 -> pred_taken=0, pred_target=0x00000044; redirect_valid=0; mispredict_count=0.
- Resolve pc=0x40, taken, target=0x100, pred_taken=0 -> next cycle redirect_valid=1, redirect_pc=0x100, count=1. Redirect held 3 cycles with ack=0. Ack -> IDLE. Lookup 0x40 -> pred_taken=1, target 0x100.
- Resolve pc=0x40 taken twice with a correct prediction -> no redirect; counter goes 10->11->11. Then not-taken resolve, pred_taken=1 -> redirect_pc=0x44, counter=10, pred_taken stays 1.
- Aliasing: entry at 0x40 exists. Resolve pc=0x1040 taken, target 0x200 -> entry replaced. Lookup 0x40 misses; lookup 0x1040 hits with target 0x200.
- In REDIRECT, pulse resolve_valid with a mispredicting branch at pc=0x80, and also with ack in the same cycle -> no table change, count unchanged, FSM returns to IDLE.
- Assert RST during REDIRECT -> next cycle redirect_valid=0 and all lookups miss. Separately, preload count to all-ones via 65535 mispredicts, then one more -> count stays 0xFFFF.
